// File: rtl/mag_buf_pkg.sv
// Shared types and helpers for the ping-pong magnitude buffer.
package mag_buf_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    // IDLE: normal operation; CLEAR: sweeping zeros through all memories.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } buf_state_t;

    // Exponential decay of a held peak: old - (old >> shift).
    // Never underflows because (old >> shift) <= old. A shift of 0 decays
    // to zero, which turns the hold off.
    function automatic logic [63:0] decay_val(input logic [63:0] old, input int shift);
        return old - (old >> shift);
    endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// A read and a write to the same address on the same edge return the old data.
module sdp_ram_1clk #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rq
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rst)     rq <= '0;
        else if (re) rq <= mem[ra];
    end

endmodule

// File: rtl/mag_pingpong_buf.sv
// Ping-pong spectrum frame buffer with per-bin decaying peak hold.
// Write side fills one bank while the renderer reads the other; a completed
// frame swaps banks once the renderer releases rd_lock.
module mag_pingpong_buf
    import mag_buf_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 2**ADDR_W,
    parameter int DECAY_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_lock,
    input  logic              peak_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] peak_data,
    output logic              rd_valid,
    output logic              frame_swap,
    output logic [15:0]       frame_cnt,
    output logic              clr_busy
);

    buf_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q;

    logic              bank_sel;     // 0: read bank 0, write bank 1
    logic              swap_pend;
    logic              rd_sel_q;     // bank_sel captured with the read
    logic              accept;

    // Peak read-modify-write pipeline (stage 2) and forwarding path.
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_data;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_val;
    logic [DATA_W-1:0] old_peak;
    logic [DATA_W-1:0] decayed;
    logic [DATA_W-1:0] new_peak;

    logic [DATA_W-1:0] bank0_q, bank1_q, peak_rmw_q;
    logic [ADDR_W-1:0] bank_wa, peak_wa;
    logic [DATA_W-1:0] bank_wd, peak_wd;
    logic              bank0_we, bank1_we, peak_we;

    // State register and clear-sweep address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= (state_q == CLEAR) ? clr_cnt_q + 1'b1 : '0;
        end
    end

    // Next-state: sweep every bin once, or start a sweep on peak_clr.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (peak_clr) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // FSM outputs: busy flag and write-side admission.
    always_comb begin
        clr_busy = 1'b0;
        wr_ready = 1'b0;
        if (state_q == CLEAR) clr_busy = 1'b1;
        if (state_q == IDLE && !swap_pend && !peak_clr) wr_ready = 1'b1;
    end

    assign accept = wr_en & wr_ready;

    // Bank write port steering: the sweep zeroes both banks, otherwise the
    // accepted magnitude goes to the bank not selected for reading.
    always_comb begin
        bank_wa  = clr_busy ? clr_cnt_q : wr_addr;
        bank_wd  = clr_busy ? '0 : wr_data;
        bank0_we = clr_busy | (accept &  bank_sel);
        bank1_we = clr_busy | (accept & ~bank_sel);
    end

    // Peak update: decayed previous peak against the new magnitude, taking
    // the previous peak from the forwarding register when the prior cycle
    // wrote the same bin.
    always_comb begin
        old_peak = fwd_hit ? fwd_val : peak_rmw_q;
        decayed  = DATA_W'(decay_val(64'(old_peak), DECAY_SHIFT));
        new_peak = (s2_data > decayed) ? s2_data : decayed;
        peak_we  = clr_busy | s2_valid;
        peak_wa  = clr_busy ? clr_cnt_q : s2_addr;
        peak_wd  = clr_busy ? '0 : new_peak;
    end

    // Stage-2 registers for the peak read-modify-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            fwd_hit  <= 1'b0;
            fwd_val  <= '0;
        end else begin
            s2_valid <= accept;
            if (accept) begin
                s2_addr <= wr_addr;
                s2_data <= wr_data;
            end
            fwd_hit <= accept & s2_valid & (s2_addr == wr_addr);
            fwd_val <= new_peak;
        end
    end

    // Bank swap handshake and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel   <= 1'b0;
            swap_pend  <= 1'b0;
            frame_swap <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_swap <= 1'b0;
            if (swap_pend && !rd_lock) begin
                bank_sel   <= ~bank_sel;
                swap_pend  <= 1'b0;
                frame_swap <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
            end else if (accept && wr_last) begin
                swap_pend <= 1'b1;
            end
        end
    end

    // Read-side bookkeeping: valid strobe and which bank the data came from.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_sel_q <= bank_sel;
        end
    end

    assign rd_data = rd_sel_q ? bank1_q : bank0_q;

    sdp_ram_1clk #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank0 (
        .clk(clk), .rst(rst),
        .we(bank0_we), .wa(bank_wa), .wd(bank_wd),
        .re(rd_en), .ra(rd_addr), .rq(bank0_q)
    );

    sdp_ram_1clk #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank1 (
        .clk(clk), .rst(rst),
        .we(bank1_we), .wa(bank_wa), .wd(bank_wd),
        .re(rd_en), .ra(rd_addr), .rq(bank1_q)
    );

    // The peak memory is one logical bank; it is held as two identically
    // written copies so the renderer read and the update read never collide.
    sdp_ram_1clk #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_peak (
        .clk(clk), .rst(rst),
        .we(peak_we), .wa(peak_wa), .wd(peak_wd),
        .re(rd_en), .ra(rd_addr), .rq(peak_data)
    );

    sdp_ram_1clk #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_peak_rmw (
        .clk(clk), .rst(rst),
        .we(peak_we), .wa(peak_wa), .wd(peak_wd),
        .re(accept), .ra(wr_addr), .rq(peak_rmw_q)
    );

endmodule

// File: tb/tb_mag_pingpong_buf.sv
// Self-checking bench for mag_pingpong_buf: frame-level model plus directed cases.
module tb_mag_pingpong_buf;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int DS    = 4;

    logic          clk = 1'b0;
    logic          rst, wr_en, wr_last, rd_en, rd_lock, peak_clr;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_valid, frame_swap, clr_busy;
    logic [DW-1:0] rd_data, peak_data;
    logic [15:0]   frame_cnt;

    mag_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .DECAY_SHIFT(DS)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_lock(rd_lock), .peak_clr(peak_clr),
        .rd_data(rd_data), .peak_data(peak_data), .rd_valid(rd_valid),
        .frame_swap(frame_swap), .frame_cnt(frame_cnt), .clr_busy(clr_busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    // Frame-level view: two bank arrays, one peak array, which bank is
    // being read, whether a finished frame awaits a swap, and how many
    // cycles of clear sweep remain. Writes land immediately; the stimulus
    // never reads a bin within two cycles of writing it.
    int m_bank [2][DEPTH];
    int m_peak [DEPTH];
    int m_sel, m_pend, m_clr_left, m_cnt;
    int e_rd, e_pk, e_valid, e_swap;
    bit started = 1'b0;

    function automatic int peak_rule(input int old, input int d);
        int dec;
        dec = old - (old >> DS);
        return (d > dec) ? d : dec;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) begin
            m_bank[0][i] = 0;
            m_bank[1][i] = 0;
            m_peak[i]    = 0;
        end
    endtask

    always @(posedge clk) begin
        bit busy, ready, acc;
        int a;
        cyc++;
        started = 1'b1;
        if (rst) begin
            model_zero();
            m_clr_left = DEPTH;
            m_sel = 0; m_pend = 0; m_cnt = 0;
            e_rd = 0; e_pk = 0; e_valid = 0; e_swap = 0;
        end else begin
            busy  = (m_clr_left > 0);
            ready = !busy && (m_pend == 0) && !peak_clr;
            acc   = wr_en && ready;
            if (rd_en) begin
                e_rd    = m_bank[m_sel][int'(rd_addr)];
                e_pk    = m_peak[int'(rd_addr)];
                e_valid = 1;
            end else begin
                e_valid = 0;
            end
            e_swap = 0;
            if (m_pend != 0 && !rd_lock) begin
                m_sel  = 1 - m_sel;
                m_pend = 0;
                e_swap = 1;
                m_cnt  = (m_cnt + 1) % 65536;
            end
            if (acc) begin
                a = int'(wr_addr);
                m_bank[1 - m_sel][a] = int'(wr_data);
                m_peak[a] = peak_rule(m_peak[a], int'(wr_data));
                if (wr_last) m_pend = 1;
            end
            if (busy) begin
                m_clr_left--;
            end else if (peak_clr) begin
                m_clr_left = DEPTH;
                model_zero();
            end
        end
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("wr_ready", int'(wr_ready),
                  int'((m_clr_left == 0) && (m_pend == 0) && !peak_clr && !rst));
            check("clr_busy", int'(clr_busy), int'(m_clr_left > 0));
            check("rd_valid", int'(rd_valid), e_valid);
            check("frame_swap", int'(frame_swap), e_swap);
            check("frame_cnt", int'(frame_cnt), m_cnt);
            check("rd_data", int'(rd_data), e_rd);
            check("peak_data", int'(peak_data), e_pk);
        end
    end

    // ---------------- driver tasks ----------------
    int acc_cyc;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input int a, input int d, input bit last);
        int n = 0;
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d); wr_last = last;
        @(negedge clk);
        while (!wr_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!wr_ready) check("send_timeout", 0, 1);
        acc_cyc = cyc;
        tick();
        wr_en = 1'b0; wr_last = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic frame(input int off, input int v5, input int a7, input int b7);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5) send(5, v5, 1'b0);
            else if (i == 7) begin
                send(7, a7, 1'b0);
                send(7, b7, 1'b0);
            end else send(i, (i + off) % 65536, i == DEPTH - 1);
        end
    endtask

    task automatic wait_swap(input int exp_delay);
        int n = 0;
        @(negedge clk);
        while (!frame_swap && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("swap_delay", cyc - acc_cyc, exp_delay);
        tick();
    endtask

    task automatic count_busy(input int exp);
        int n = 0;
        @(negedge clk);
        while (clr_busy && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, exp);
        tick();
    endtask

    task automatic read_all_zero();
        int sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            sum += int'(rd_data) + int'(peak_data);
        end
        check("all_zero_sum", sum, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_lock = 1'b0;
        peak_clr = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) tick();
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        count_busy(256);
        read_all_zero();

        // Frame 1: bin i = i, bin 5 = 1000.
        frame(0, 1000, 7, 7);
        wait_swap(2);
        check("frame_cnt_1", int'(frame_cnt), 1);
        rd(10);
        check("f1_rd10", int'(rd_data), 10);
        check("f1_valid", int'(rd_valid), 1);
        rd(5);
        check("f1_peak5", int'(peak_data), 1000);

        // Frame 2: bin 5 = 0 decays 1000 -> 938; bin 7: 500 then 800.
        frame(0, 0, 500, 800);
        wait_swap(2);
        rd(5);
        check("f2_rd5", int'(rd_data), 0);
        check("f2_peak5", int'(peak_data), 938);
        rd(7);
        check("f2_peak7", int'(peak_data), 800);

        // Frame 3: bin 7: 800 then 500 -> max(500, 800-50) = 750.
        frame(0, 5, 800, 500);
        wait_swap(2);
        rd(7);
        check("f3_peak7", int'(peak_data), 750);
        check("frame_cnt_3", int'(frame_cnt), 3);

        // Frame 4 under rd_lock: swap deferred, old frame still readable.
        rd_lock = 1'b1;
        frame(2, 5, 7, 7);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("lock_wr_ready", int'(wr_ready), 0);
            tick();
        end
        rd(10);
        check("lock_old_frame", int'(rd_data), 10);
        rd_lock = 1'b0;
        @(negedge clk);
        check("unlock_swap_0", int'(frame_swap), 0);
        @(negedge clk);
        check("unlock_swap_1", int'(frame_swap), 1);
        tick();
        rd(10);
        check("f4_rd10", int'(rd_data), 12);
        check("frame_cnt_4", int'(frame_cnt), 4);

        // peak_clr mid-frame with a write attempted in the same cycle.
        for (int i = 0; i < 10; i++) send(i, 3000 + i, 1'b0);
        wr_en = 1'b1; wr_addr = AW'(10); wr_data = DW'(99); peak_clr = 1'b1;
        @(negedge clk);
        check("clr_blocks_write", int'(wr_ready), 0);
        tick();
        wr_en = 1'b0; peak_clr = 1'b0;
        count_busy(256);
        read_all_zero();

        // rst during a sweep restarts it from the beginning.
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        count_busy(256);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        for (int i = 0; i < 8; i++) rd(i * 37);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
